// File: rtl/nes_pad_responder.sv
// APB3 slave emulating an NES gamepad (4021 shift register) on pad_latch/pad_clock/pad_data.
// Optional turbo masking is compiled in with `define NES_PAD_TURBO_EN.
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TURBO_FRAMES = 4
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        pad_latch,
    input  logic        pad_clock,
    output logic        pad_data,
    output logic        FABINT
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

    localparam logic [11:0] A_BUTTONS = 12'h000;
    localparam logic [11:0] A_STATUS  = 12'h004;
    localparam logic [11:0] A_CTRL    = 12'h008;
    localparam logic [11:0] A_TURBO   = 12'h00C;

    logic [SYNC_STAGES-1:0] latch_sync_q, clock_sync_q;
    logic                   latch_prev_q, clock_prev_q;
    logic                   latch_s, clock_s, latch_rise, clock_rise;

    state_e      state_q, state_d;
    logic [7:0]  buttons_q, sr_q, sr_d, load_val;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  frame_cnt_q;
    logic        frame_done_q, frame_done_d, frame_end;
    logic        enable_q, irq_en_q;
    logic        pad_data_q, pad_data_d;
    logic [31:0] prdata_q, rdata;
    logic        apb_wr, apb_rd;
    logic [11:0] addr;
    logic        unused_bits;

    assign addr        = PADDR[11:0];
    assign apb_wr      = PSEL & PENABLE & PWRITE;
    assign apb_rd      = PSEL & ~PWRITE;
    assign unused_bits = ^{PADDR[31:12], PWDATA[31:8]};

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign clock_s    = clock_sync_q[SYNC_STAGES-1];
    assign latch_rise = latch_s & ~latch_prev_q;
    assign clock_rise = clock_s & ~clock_prev_q;

`ifdef NES_PAD_TURBO_EN
    logic [7:0] turbo_q, turbo_cnt_q;
    logic       turbo_phase_q;

    assign load_val = buttons_q & ~(turbo_q & {8{turbo_phase_q}});

    // Phase flips once every TURBO_FRAMES completed frames.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            turbo_q       <= '0;
            turbo_cnt_q   <= '0;
            turbo_phase_q <= 1'b0;
        end else begin
            if (apb_wr && addr == A_TURBO) turbo_q <= PWDATA[7:0];
            if (frame_end) begin
                if (turbo_cnt_q == 8'(TURBO_FRAMES - 1)) begin
                    turbo_cnt_q   <= '0;
                    turbo_phase_q <= ~turbo_phase_q;
                end else begin
                    turbo_cnt_q <= turbo_cnt_q + 8'd1;
                end
            end
        end
    end
`else
    logic unused_turbo;
    assign load_val     = buttons_q;
    assign unused_turbo = TURBO_FRAMES[0];
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            A_BUTTONS: rdata[7:0] = buttons_q;
            A_STATUS:  rdata = {8'h00, frame_cnt_q, 7'h00, frame_done_q, 4'h0, bit_cnt_q};
            A_CTRL:    rdata[1:0] = {irq_en_q, enable_q};
`ifdef NES_PAD_TURBO_EN
            A_TURBO:   rdata[7:0] = turbo_q;
`endif
            default:   rdata = '0;
        endcase
    end

    // Latch rise has top priority so a reload always wins over a same-cycle clock edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        frame_end = 1'b0;
        if (!enable_q) begin
            state_d = S_IDLE;
        end else if (latch_rise) begin
            state_d   = S_LOAD;
            sr_d      = load_val;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    bit_cnt_d = '0;
                    if (latch_s) sr_d = load_val;
                    else         state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (clock_rise && !latch_s) begin
                        sr_d      = {sr_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d   = S_DONE;
                            frame_end = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        pad_data_d = (state_d == S_LOAD || state_d == S_SHIFT) ? ~sr_d[7] : 1'b1;

        frame_done_d = frame_done_q;
        if (frame_end)                                    frame_done_d = 1'b1;
        else if (apb_wr && addr == A_CTRL && PWDATA[2])   frame_done_d = 1'b0;
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            latch_sync_q <= '0;
            clock_sync_q <= '0;
            latch_prev_q <= 1'b0;
            clock_prev_q <= 1'b0;
            state_q      <= S_IDLE;
            buttons_q    <= '0;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            pad_data_q   <= 1'b1;
            prdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad_latch};
            clock_sync_q <= {clock_sync_q[SYNC_STAGES-2:0], pad_clock};
            latch_prev_q <= latch_s;
            clock_prev_q <= clock_s;
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
            pad_data_q   <= pad_data_d;
            if (frame_end) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (apb_wr && addr == A_BUTTONS) buttons_q <= PWDATA[7:0];
            if (apb_wr && addr == A_CTRL) begin
                enable_q <= PWDATA[0];
                irq_en_q <= PWDATA[1];
            end
            if (apb_rd) prdata_q <= rdata;
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign pad_data = pad_data_q;
    assign FABINT   = frame_done_q & irq_en_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: table-driven frames plus hand-written corner cases,
// all checked through an expected-value scoreboard queue.
module tb_nes_pad_responder;

    logic        PCLK = 1'b0;
    logic        PRESERN, PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        pad_latch, pad_clock, pad_data, FABINT;

    nes_pad_responder dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .pad_latch(pad_latch), .pad_clock(pad_clock), .pad_data(pad_data), .FABINT(FABINT)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [7:0] buttons;
        logic [7:0] serial;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic expect_val(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %h with no expectation queued", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h, want %h", e.name, act, e.val);
            end
        end
    endtask

    function automatic logic [31:0] mk_status(input int fcnt, input bit fd, input int bc);
        return {8'h00, 8'(fcnt), 7'h00, fd, 4'h0, 4'(bc)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        tick(1);
        PENABLE = 1'b1;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0;
        d = PRDATA;
    endtask

    task automatic set_latch(input logic v);
        pad_latch = v;
        tick(5);
    endtask

    task automatic set_clock(input logic v);
        pad_clock = v;
        tick(5);
    endtask

    task automatic latch_pulse();
        set_latch(1'b1);
        set_latch(1'b0);
    endtask

    task automatic clock_pulse();
        set_clock(1'b1);
        set_clock(1'b0);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] want);
        logic [31:0] d;
        expect_val(name, want);
        apb_read(a, d);
        check(d);
    endtask

    task automatic pad_check(input string name, input logic want);
        expect_val(name, {31'b0, want});
        check({31'b0, pad_data});
    endtask

    // Latch then shift all 8 bits, checking pad_data after the latch and after every clock.
    task automatic frame_check(input logic [7:0] serial);
        latch_pulse();
        pad_check("pad_after_latch", serial[7]);
        for (int k = 1; k < 8; k++) begin
            clock_pulse();
            pad_check($sformatf("pad_bit%0d", k), serial[7-k]);
        end
        clock_pulse();
        pad_check("pad_after_8th", 1'b1);
    endtask

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        vecs[0] = '{buttons: 8'hA5, serial: 8'h5A};
        vecs[1] = '{buttons: 8'h00, serial: 8'hFF};
        vecs[2] = '{buttons: 8'hFF, serial: 8'h00};
        vecs[3] = '{buttons: 8'h3C, serial: 8'hC3};

        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; pad_latch = 1'b0; pad_clock = 1'b0;
        tick(3);
        pad_check("rst_pad", 1'b1);
        expect_val("rst_fabint", 32'd0);  check({31'b0, FABINT});
        expect_val("rst_prdata", 32'd0);  check(PRDATA);
        expect_val("pready", 32'd1);      check({31'b0, PREADY});
        expect_val("pslverr", 32'd0);     check({31'b0, PSLVERR});
        PRESERN = 1'b1;
        tick(2);
        read_check("rst_status", 32'h004, 32'h0);

        // Disabled after reset: a full latch/clock sequence must leave pad_data idle.
        apb_write(32'h000, 32'h80);
        latch_pulse();
        pad_check("dis_pad_latch", 1'b1);
        clock_pulse();
        read_check("dis_status", 32'h004, 32'h0);

        apb_write(32'h008, 32'h1);
        for (int i = 0; i < 4; i++) begin
            apb_write(32'h000, {24'h0, vecs[i].buttons});
            read_check("buttons_rb", 32'h000, {24'h0, vecs[i].buttons});
            frame_check(vecs[i].serial);
            read_check($sformatf("status_vec%0d", i), 32'h004, mk_status(i + 1, 1'b1, 8));
        end

        // Extra clocks after the frame are ignored.
        for (int k = 0; k < 4; k++) begin
            clock_pulse();
            pad_check("pad_extra_clk", 1'b1);
        end
        read_check("status_extra", 32'h004, mk_status(4, 1'b1, 8));

        // Mid-frame abort: clear frame_done, shift 3 bits, then reload new buttons.
        apb_write(32'h008, 32'h5);
        apb_write(32'h000, 32'h80);
        latch_pulse();
        pad_check("abort_pad0", 1'b0);
        for (int k = 0; k < 3; k++) clock_pulse();
        pad_check("abort_pad3", 1'b1);
        apb_write(32'h000, 32'hFF);
        latch_pulse();
        pad_check("abort_reload_pad", 1'b0);
        read_check("abort_status", 32'h004, mk_status(4, 1'b0, 0));
        for (int k = 0; k < 8; k++) clock_pulse();
        read_check("abort_done_status", 32'h004, mk_status(5, 1'b1, 8));

        // Latch and clock rising together: the reload wins, no shift is counted.
        latch_pulse();
        clock_pulse();
        clock_pulse();
        pad_latch = 1'b1; pad_clock = 1'b1;
        tick(5);
        pad_latch = 1'b0; pad_clock = 1'b0;
        tick(5);
        read_check("same_cycle_status", 32'h004, mk_status(5, 1'b1, 0));

        // Interrupt: arm, complete a frame, then clear through W1C.
        apb_write(32'h008, 32'h5);
        apb_write(32'h008, 32'h3);
        expect_val("fabint_armed_low", 32'd0);  check({31'b0, FABINT});
        for (int k = 0; k < 8; k++) clock_pulse();
        expect_val("fabint_set", 32'd1);        check({31'b0, FABINT});
        apb_write(32'h008, 32'h7);
        expect_val("fabint_w1c", 32'd0);        check({31'b0, FABINT});
        read_check("status_w1c", 32'h004, mk_status(6, 1'b0, 8));
        read_check("ctrl_rb", 32'h008, 32'h3);

        // Disable during shift forces idle; clocks are then ignored.
        latch_pulse();
        pad_check("pre_disable_pad", 1'b0);
        apb_write(32'h008, 32'h2);
        tick(1);
        pad_check("disable_pad", 1'b1);
        for (int k = 0; k < 3; k++) clock_pulse();
        read_check("disable_status", 32'h004, mk_status(6, 1'b0, 0));

        // Re-enable with latch already high must wait for a fresh rise.
        set_latch(1'b1);
        apb_write(32'h008, 32'h3);
        tick(5);
        pad_check("reenable_no_rise", 1'b1);
        set_latch(1'b0);
        pad_check("reenable_still_idle", 1'b1);
        frame_check(8'h00);
        expect_val("fabint_reenabled", 32'd1);  check({31'b0, FABINT});

        // Asynchronous reset in the middle of a shift.
        latch_pulse();
        for (int k = 0; k < 3; k++) clock_pulse();
        pad_check("pre_reset_pad", 1'b0);
        #2 PRESERN = 1'b0;
        #1;
        pad_check("async_rst_pad", 1'b1);
        expect_val("async_rst_fabint", 32'd0);  check({31'b0, FABINT});
        expect_val("async_rst_prdata", 32'd0);  check(PRDATA);
        tick(2);
        PRESERN = 1'b1;
        tick(2);
        read_check("post_rst_status", 32'h004, 32'h0);
        read_check("post_rst_ctrl", 32'h008, 32'h0);
        read_check("post_rst_buttons", 32'h000, 32'h0);

`ifdef NES_PAD_TURBO_EN
        apb_write(32'h008, 32'h1);
        apb_write(32'h000, 32'h80);
        apb_write(32'h00C, 32'h80);
        read_check("turbo_rb", 32'h00C, 32'h80);
        for (int f = 0; f < 8; f++) begin
            latch_pulse();
            pad_check($sformatf("turbo_frame%0d", f + 1), (f < 4) ? 1'b0 : 1'b1);
            for (int k = 0; k < 8; k++) clock_pulse();
        end
`else
        apb_write(32'h00C, 32'hFF);
        read_check("turbo_absent", 32'h00C, 32'h0);
`endif

        expect_val("sb_drained", 32'd0);
        check(32'(sb_q.size() - 1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
